// File: rtl/four_bit_adder_subtractor.sv
// four_bit_adder_subtractor: registered 4-bit ripple-carry adder/subtractor with carry, overflow and zero flags
module four_bit_adder_subtractor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       subtract,
  input  logic       in_valid,
  output logic [3:0] Result,
  output logic       Cout,
  output logic       Overflow,
  output logic       Zero,
  output logic       out_valid
);
  logic [3:0] bx, s;
  logic [4:0] c;
  assign bx   = B ^ {4{subtract}};
  assign c[0] = subtract;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = A[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
  end
  // Capture the chain output on accepted inputs; flags hold while idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Result    <= 4'b0000;
      Cout      <= 1'b0;
      Overflow  <= 1'b0;
      Zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Result   <= s;
        Cout     <= c[4];
        Overflow <= c[3] ^ c[4];
        Zero     <= s == 4'b0000;
      end
    end
  end
endmodule

// File: tb/tb_four_bit_adder_subtractor.sv
// tb_four_bit_adder_subtractor: directed-vector and exhaustive check of the adder/subtractor
module tb_four_bit_adder_subtractor;
  logic       clk = 1'b0;
  logic       rst_n, subtract, in_valid;
  logic [3:0] A, B, Result;
  logic       Cout, Overflow, Zero, out_valid;
  int         tests = 0;
  int         fails = 0;

  typedef struct {
    logic [3:0] a, b;
    logic       sub;
    logic [3:0] res;
    logic       cout, ov, z;
  } vec_t;

  vec_t vecs[14];

  four_bit_adder_subtractor dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .subtract(subtract), .in_valid(in_valid),
    .Result(Result), .Cout(Cout), .Overflow(Overflow), .Zero(Zero), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] exp);
    logic [7:0] got;
    got = {out_valid, Result, Cout, Overflow, Zero};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got {ov,res,c,o,z}=%b required=%b", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b, input logic s);
    rst_n = r; in_valid = v; A = a; B = b; subtract = s;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b, input logic s);
    int u, sv;
    logic [3:0] r;
    u  = s ? int'(a) + int'(~b & 4'hf) + 1 : int'(a) + int'(b);
    sv = s ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
    r  = u[3:0];
    return {r, u[4], (sv > 7 || sv < -8), r == 4'b0000};
  endfunction

  initial begin
    logic [6:0] last, m;
    vecs[0]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'b0010, 4'b0001, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{4'b0011, 4'b0010, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'b1001, 4'b0010, 1'b0, 4'b1011, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'b0100, 4'b0011, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{4'b0010, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{4'b0011, 4'b0010, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{4'b1001, 4'b0010, 1'b1, 4'b0111, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{4'b0100, 4'b0011, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{4'b0010, 4'b0011, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'b0101, 4'b0101, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1};
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    chk("reset_state", 8'b0);
    foreach (vecs[i])
      begin
        drive(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].sub);
        chk($sformatf("vec%0d", i), {1'b1, vecs[i].res, vecs[i].cout, vecs[i].ov, vecs[i].z});
      end
    drive(1'b1, 1'b1, 4'b0111, 4'b0001, 1'b0);
    chk("ovf_load", {1'b1, 4'b1000, 1'b0, 1'b1, 1'b0});
    A = 4'b0101; B = 4'b0101; subtract = 1'b1; in_valid = 1'b0;
    #2;
    chk("midcycle_inputs", {1'b1, 4'b1000, 1'b0, 1'b1, 1'b0});
    drive(1'b1, 1'b0, 4'b0101, 4'b0101, 1'b1);
    chk("idle_hold", {1'b0, 4'b1000, 1'b0, 1'b1, 1'b0});
    rst_n = 1'b0;
    #2;
    chk("async_rst_ignored", {1'b0, 4'b1000, 1'b0, 1'b1, 1'b0});
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 4'b0011, 4'b0011, 1'b0);
    chk("pre_reset_load", {1'b1, 4'b0110, 1'b0, 1'b0, 1'b0});
    drive(1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0);
    chk("reset_priority", 8'b0);
    drive(1'b1, 1'b0, 4'b1111, 4'b0001, 1'b0);
    chk("post_reset_hold", 8'b0);
    drive(1'b1, 1'b1, 4'b0110, 4'b0001, 1'b1);
    chk("first_after_reset", {1'b1, 4'b0101, 1'b1, 1'b0, 1'b0});
    last = {4'b0101, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 512; k++) begin
      if ($urandom_range(3) == 0) begin
        drive(1'b1, 1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
        chk("gap_hold", {1'b0, last});
      end
      m = model(k[3:0], k[7:4], k[8]);
      drive(1'b1, 1'b1, k[3:0], k[7:4], k[8]);
      chk($sformatf("sweep a=%0d b=%0d s=%0d", k[3:0], k[7:4], k[8]), {1'b1, m});
      last = m;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
